id_hazard_unit: RTL and testbench

ID_HAZARD_UNIT -- requirements
Module: id_hazard_unit

---
 rtl/id_hazard_unit.sv | 134 +++++++++++++
 tb/tb_id_hazard_unit.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/id_hazard_unit.sv
// id_hazard_unit: decode-stage operand forwarding and load-use interlock.
// Tracks in-flight destinations and picks the youngest final result per source.
module id_hazard_unit #(
    parameter int DATA_W    = 16,
    parameter int REG_AW    = 4,
    parameter int FWD_DEPTH = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        id_valid,
    input  logic [REG_AW-1:0]           id_rs1,
    input  logic [REG_AW-1:0]           id_rs2,
    input  logic [REG_AW-1:0]           id_rd,
    input  logic                        id_is_load,
    input  logic [DATA_W-1:0]           rf1_data,
    input  logic [DATA_W-1:0]           rf2_data,
    input  logic [FWD_DEPTH*DATA_W-1:0] stg_data,
    input  logic [FWD_DEPTH-1:0]        stg_ok,
    input  logic                        flush,
    input  logic                        out_ready,
    output logic [DATA_W-1:0]           op1,
    output logic [DATA_W-1:0]           op2,
    output logic                        out_valid,
    output logic [REG_AW-1:0]           out_rd,
    output logic                        stall,
    output logic [15:0]                 stall_cnt
);

    localparam logic [REG_AW-1:0] REG_INVALID = '1;
    localparam logic [0:0] RUN  = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    typedef struct packed {
        logic              v;
        logic [REG_AW-1:0] rd;
        logic              ld;
    } trk_t;

    localparam trk_t BUBBLE = '{v: 1'b0, rd: REG_INVALID, ld: 1'b0};

    trk_t              r_trk [FWD_DEPTH];
    logic [DATA_W-1:0] r_op1;
    logic [DATA_W-1:0] r_op2;
    logic              r_out_valid;
    logic [REG_AW-1:0] r_out_rd;
    logic [15:0]       r_stall_cnt;
    logic [0:0]        r_state;

    logic [DATA_W-1:0] w_fwd1;
    logic [DATA_W-1:0] w_fwd2;
    logic              w_pend1;
    logic              w_pend2;
    logic              w_hz_stall;
    logic              w_issue;
    logic [0:0]        w_state_nxt;

    // Descending scan so the lowest-index (youngest) match wins.
    always_comb begin
        w_fwd1  = rf1_data;
        w_fwd2  = rf2_data;
        w_pend1 = 1'b0;
        w_pend2 = 1'b0;
        for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
            if (r_trk[k].v && r_trk[k].rd == id_rs1 &&
                id_rs1 != REG_INVALID) begin
                w_fwd1  = stg_data[k*DATA_W +: DATA_W];
                w_pend1 = ~stg_ok[k];
            end
            if (r_trk[k].v && r_trk[k].rd == id_rs2 &&
                id_rs2 != REG_INVALID) begin
                w_fwd2  = stg_data[k*DATA_W +: DATA_W];
                w_pend2 = ~stg_ok[k];
            end
        end
    end

    assign w_hz_stall = id_valid & ~flush & (w_pend1 | w_pend2);
    assign w_issue    = id_valid & ~flush;
    assign stall      = w_hz_stall | ~out_ready;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            RUN:     if (stall)  w_state_nxt = HOLD;
            HOLD:    if (!stall) w_state_nxt = RUN;
            default: w_state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < FWD_DEPTH; k++) begin
                r_trk[k] <= BUBBLE;
            end
            r_op1       <= '0;
            r_op2       <= '0;
            r_out_valid <= 1'b0;
            r_out_rd    <= REG_INVALID;
            r_stall_cnt <= '0;
        end else if (out_ready) begin
            for (int k = FWD_DEPTH - 1; k > 0; k--) begin
                r_trk[k] <= r_trk[k-1];
            end
            if (w_hz_stall) begin
                r_trk[0]    <= BUBBLE;
                r_out_valid <= 1'b0;
                if (r_stall_cnt != 16'hFFFF) begin
                    r_stall_cnt <= r_stall_cnt + 16'd1;
                end
            end else begin
                r_trk[0]    <= '{v: w_issue, rd: id_rd, ld: id_is_load};
                r_op1       <= w_fwd1;
                r_op2       <= w_fwd2;
                r_out_rd    <= id_rd;
                r_out_valid <= w_issue;
            end
        end
    end

    assign op1       = r_op1;
    assign op2       = r_op2;
    assign out_valid = r_out_valid;
    assign out_rd    = r_out_rd;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_id_hazard_unit.sv
// tb_id_hazard_unit: directed vector table plus reset and saturation
// sequences for the decode hazard unit (FWD_DEPTH=8).
module tb_id_hazard_unit;

    logic         clk = 1'b0;
    logic         rst;
    logic         id_valid;
    logic [3:0]   id_rs1;
    logic [3:0]   id_rs2;
    logic [3:0]   id_rd;
    logic         id_is_load;
    logic [15:0]  rf1_data;
    logic [15:0]  rf2_data;
    logic [127:0] stg_data;
    logic [7:0]   stg_ok;
    logic         flush;
    logic         out_ready;
    logic [15:0]  op1;
    logic [15:0]  op2;
    logic         out_valid;
    logic [3:0]   out_rd;
    logic         stall;
    logic [15:0]  stall_cnt;

    int n_chk = 0;
    int n_err = 0;

    id_hazard_unit #(
        .DATA_W(16),
        .REG_AW(4),
        .FWD_DEPTH(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .id_valid(id_valid),
        .id_rs1(id_rs1),
        .id_rs2(id_rs2),
        .id_rd(id_rd),
        .id_is_load(id_is_load),
        .rf1_data(rf1_data),
        .rf2_data(rf2_data),
        .stg_data(stg_data),
        .stg_ok(stg_ok),
        .flush(flush),
        .out_ready(out_ready),
        .op1(op1),
        .op2(op2),
        .out_valid(out_valid),
        .out_rd(out_rd),
        .stall(stall),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int v;
        int rs1;
        int rs2;
        int rd;
        int ld;
        int rf1;
        int rf2;
        int sd0;
        int sd1;
        int sd2;
        int ok;
        int fl;
        int rdy;
        int e_st;
        int e_op1;
        int e_op2;
        int e_ov;
        int e_rd;
        int e_cnt;
        int chk_ops;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        id_valid   = t.v[0];
        id_rs1     = 4'(t.rs1);
        id_rs2     = 4'(t.rs2);
        id_rd      = 4'(t.rd);
        id_is_load = t.ld[0];
        rf1_data   = 16'(t.rf1);
        rf2_data   = 16'(t.rf2);
        stg_data   = {{5{16'hEEEE}}, 16'(t.sd2), 16'(t.sd1), 16'(t.sd0)};
        stg_ok     = 8'(t.ok);
        flush      = t.fl[0];
        out_ready  = t.rdy[0];
    endtask

    task automatic apply(input vec_t t, input string tag);
        drive(t);
        #1;
        chk({tag, ".stall"}, int'(stall), t.e_st);
        @(posedge clk);
        #1;
        chk({tag, ".out_valid"}, int'(out_valid), t.e_ov);
        chk({tag, ".stall_cnt"}, int'(stall_cnt), t.e_cnt);
        if (t.chk_ops != 0) begin
            chk({tag, ".op1"}, int'(op1), t.e_op1);
            chk({tag, ".op2"}, int'(op2), t.e_op2);
            chk({tag, ".out_rd"}, int'(out_rd), t.e_rd);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".op1"}, int'(op1), 0);
        chk({tag, ".op2"}, int'(op2), 0);
        chk({tag, ".out_valid"}, int'(out_valid), 0);
        chk({tag, ".out_rd"}, int'(out_rd), 'hF);
        chk({tag, ".stall_cnt"}, int'(stall_cnt), 0);
    endtask

    initial begin
        vec_t t;
        //         v rs1 rs2 rd ld  rf1     rf2     sd0     sd1     sd2    ok  fl rdy st e_op1   e_op2   ov rd  cnt ck
        vecs[0]  = '{1, 2, 3, 7, 0, 'h0011, 'h0022, 0,      0,      0,     'hFF, 0, 1, 0, 'h0011, 'h0022, 1, 7,  0, 1};
        vecs[1]  = '{1, 1, 4, 2, 0, 'h0101, 'h0404, 0,      0,      0,     'hFF, 0, 1, 0, 'h0101, 'h0404, 1, 2,  0, 1};
        vecs[2]  = '{1, 8, 9, 2, 0, 'h0808, 'h0909, 0,      0,      0,     'hFF, 0, 1, 0, 'h0808, 'h0909, 1, 2,  0, 1};
        vecs[3]  = '{1, 2, 7, 3, 0, 0,      0,      'hAAAA, 'hBBBB, 'hCCCC,'hFF, 0, 1, 0, 'hAAAA, 'hCCCC, 1, 3,  0, 1};
        vecs[4]  = '{1, 3, 2, 15,0, 0,      0,      'h1111, 'h2222, 'h3333,'hFF, 0, 1, 0, 'h1111, 'h2222, 1, 15, 0, 1};
        vecs[5]  = '{1, 15,15,4, 0, 'h5A5A, 'hA5A5, 0,      0,      0,     0,    0, 1, 0, 'h5A5A, 'hA5A5, 1, 4,  0, 1};
        vecs[6]  = '{0, 1, 1, 4, 0, 'h1234, 'h1234, 0,      0,      0,     0,    0, 1, 0, 'h1234, 'h1234, 0, 4,  0, 1};
        vecs[7]  = '{1, 4, 0, 5, 1, 'h9999, 'h0F0F, 'hDEAD, 'hBEEF, 0,     'hFF, 0, 1, 0, 'hBEEF, 'h0F0F, 1, 5,  0, 1};
        vecs[8]  = '{1, 5, 0, 6, 0, 0,      'h0002, 0,      0,      0,     0,    0, 1, 1, 'hBEEF, 'h0F0F, 0, 5,  1, 1};
        vecs[9]  = '{1, 5, 0, 6, 0, 0,      'h0002, 0,      0,      0,     0,    0, 1, 1, 'hBEEF, 'h0F0F, 0, 5,  2, 1};
        vecs[10] = '{1, 5, 0, 6, 0, 0,      'h0002, 0,      0,      'h7777,'hFF, 0, 1, 0, 'h7777, 'h0002, 1, 6,  2, 1};
        vecs[11] = '{1, 6, 0, 8, 0, 0,      0,      0,      0,      0,     0,    1, 1, 0, 0,      0,      0, 0,  2, 0};
        vecs[12] = '{1, 6, 6, 9, 0, 0,      0,      0,      'h6666, 0,     'h02, 0, 1, 0, 'h6666, 'h6666, 1, 9,  2, 1};
        vecs[13] = '{1, 9, 0, 10,0, 0,      0,      0,      0,      0,     0,    0, 0, 1, 'h6666, 'h6666, 1, 9,  2, 1};
        vecs[14] = '{1, 9, 0, 10,0, 0,      0,      0,      0,      0,     0,    0, 0, 1, 'h6666, 'h6666, 1, 9,  2, 1};
        vecs[15] = '{1, 9, 0, 10,0, 0,      0,      0,      0,      0,     0,    0, 0, 1, 'h6666, 'h6666, 1, 9,  2, 1};
        vecs[16] = '{1, 9, 0, 10,0, 0,      0,      0,      0,      0,     0,    0, 1, 1, 'h6666, 'h6666, 0, 9,  3, 1};
        vecs[17] = '{1, 9, 0, 10,0, 'h1357, 'h2468, 0,      0,      0,     0,    0, 1, 0, 'h1357, 'h2468, 1, 10, 0, 1};

        t = vecs[0];
        t.v = 0;
        drive(t);
        rst = 1'b1;
        #1;
        chk_reset("reset0");
        chk("reset0.stall", int'(stall), 0);
        @(posedge clk);
        #2;
        rst = 1'b0;

        for (int i = 0; i < NV - 1; i++) begin
            apply(vecs[i], $sformatf("v%0d", i));
        end

        // Reset pulse while held in a hazard stall.
        drive(vecs[16]);
        #3;
        rst = 1'b1;
        #1;
        chk_reset("rst_hold");
        chk("rst_hold.stall", int'(stall), 0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        apply(vecs[17], "post_rst");

        // Self-dependent instruction: one issue then eight stalls, repeating.
        rst = 1'b1;
        #1;
        chk_reset("rst_sat");
        @(posedge clk);
        #2;
        rst = 1'b0;
        t = vecs[17];
        t.rs1 = 10;
        t.rs2 = 15;
        t.rd  = 10;
        drive(t);
        repeat (900) @(posedge clk);
        #1;
        chk("sat.cnt800", int'(stall_cnt), 800);
        chk("sat.issue_stall", int'(stall), 0);
        @(posedge clk);
        #1;
        chk("sat.cnt_issue", int'(stall_cnt), 800);
        chk("sat.next_stall", int'(stall), 1);
        repeat (73000) @(posedge clk);
        #1;
        chk("sat.cnt_max", int'(stall_cnt), 'hFFFF);
        repeat (20) @(posedge clk);
        #1;
        chk("sat.cnt_hold", int'(stall_cnt), 'hFFFF);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
